// File: rtl/peak_dpu_br_ctrl_if.sv
// ---------------------------------------------------------------------------
// peak_dpu_br_ctrl_if
// Bundle between the branch controller and its neighbours.
//   issue    : br_vld/br_rdy plus the decoded branch and its operands
//   redirect : redirect_vld/redirect_pc/redirect_ack plus the flush pulse
//   link wb  : wb_vld/wb_addr/wb_data/wb_ack
// Modports:
//   master - decoder/fetch/regfile side (drives issue fields and acks)
//   slave  - branch controller side
// ---------------------------------------------------------------------------
interface peak_dpu_br_ctrl_if;
  logic        br_vld;
  logic        br_rdy;
  logic [2:0]  br_op;
  logic [31:0] br_pc;
  logic        br_is_compressed;
  logic [31:0] br_imm;
  logic        br_use_imm;
  logic        br_wr_vld;
  logic [4:0]  br_wr_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        redirect_ack;
  logic        flush;

  logic        wb_vld;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ack;

  modport master (
    output br_vld, br_op, br_pc, br_is_compressed, br_imm, br_use_imm,
           br_wr_vld, br_wr_addr, rs1_data, rs2_data, redirect_ack, wb_ack,
    input  br_rdy, redirect_vld, redirect_pc, flush, wb_vld, wb_addr, wb_data
  );

  modport slave (
    input  br_vld, br_op, br_pc, br_is_compressed, br_imm, br_use_imm,
           br_wr_vld, br_wr_addr, rs1_data, rs2_data, redirect_ack, wb_ack,
    output br_rdy, redirect_vld, redirect_pc, flush, wb_vld, wb_addr, wb_data
  );
endinterface

// File: rtl/peak_dpu_br_ctrl.sv
// ---------------------------------------------------------------------------
// peak_dpu_br_ctrl
// Branch execution controller: accepts one decoded branch/jump, resolves the
// condition, then issues a fetch redirect (with a one-cycle flush pulse) and
// a link write-back, each through its own valid/ack handshake. Keeps a
// saturating count of taken redirects.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   bus          - issue / redirect / write-back bundle (slave side)
//   kill         - abort: forces IDLE on the next edge, drops all requests
//   cnt_clr      - synchronous clear of taken_cnt (wins over an increment)
//   busy         - state is not IDLE
//   taken_cnt    - saturating count of taken redirects
//   dbg_state_o  - current FSM state (0=IDLE, 1=EXEC, 2=RESP)
//
// Handshakes: a transfer happens on a rising edge where valid and
// ready/ack are both high. br_rdy is the only ready that depends
// combinationally on an input (kill). redirect_vld and wb_vld are registers:
// once raised they hold with a stable payload until their ack is sampled,
// and drop on the following cycle. An ack seen while its valid is low has no
// effect.
// ---------------------------------------------------------------------------
module peak_dpu_br_ctrl #(
  parameter int unsigned RST_PC_W = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  peak_dpu_br_ctrl_if.slave  bus,
  input  logic               kill,
  input  logic               cnt_clr,
  output logic               busy,
  output logic [CNT_W-1:0]   taken_cnt,
  output logic [1:0]         dbg_state_o
);

  localparam logic [2:0] OP_JAL  = 3'd0;
  localparam logic [2:0] OP_JALR = 3'd1;
  localparam logic [2:0] OP_BEQ  = 3'd2;
  localparam logic [2:0] OP_BNE  = 3'd3;
  localparam logic [2:0] OP_BLT  = 3'd4;
  localparam logic [2:0] OP_BGE  = 3'd5;
  localparam logic [2:0] OP_BLTU = 3'd6;
  localparam logic [2:0] OP_BGEU = 3'd7;

  localparam logic [RST_PC_W-1:0] ONE  = 1;
  localparam logic [RST_PC_W-1:0] TWO  = 2;
  localparam logic [RST_PC_W-1:0] FOUR = 4;
  localparam logic [CNT_W-1:0]    CNT_ONE = 1;
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Branch registered at accept
  logic [2:0]          op_q;
  logic [RST_PC_W-1:0] pc_q, imm_q, rs1_q, rs2_q;
  logic                comp_q, use_imm_q, wr_vld_q;
  logic [4:0]          wr_addr_q;

  // Response registers
  logic                redir_vld_q, redir_vld_d;
  logic                wb_vld_q, wb_vld_d;
  logic                flush_q, flush_d;
  logic [RST_PC_W-1:0] redir_pc_q, wb_data_q;
  logic [4:0]          wb_addr_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic                taken, need_wb, inc;
  logic [RST_PC_W-1:0] target, link, jalr_sum;

  assign accept = bus.br_vld && bus.br_rdy;

  // ---------------- resolve (valid while in EXEC) ----------------
  always_comb begin
    taken = 1'b0;
    case (op_q)
      OP_JAL, OP_JALR: taken = 1'b1;
      OP_BEQ:  taken = (rs1_q == rs2_q);
      OP_BNE:  taken = (rs1_q != rs2_q);
      OP_BLT:  taken = ($signed(rs1_q) <  $signed(rs2_q));
      OP_BGE:  taken = ($signed(rs1_q) >= $signed(rs2_q));
      OP_BLTU: taken = (rs1_q <  rs2_q);
      OP_BGEU: taken = (rs1_q >= rs2_q);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum = rs1_q + (use_imm_q ? imm_q : '0);
  assign target   = (op_q == OP_JALR) ? (jalr_sum & ~ONE) : (pc_q + imm_q);
  assign link     = pc_q + (comp_q ? TWO : FOUR);
  assign need_wb  = wr_vld_q && ((op_q == OP_JAL) || (op_q == OP_JALR)) &&
                    (wr_addr_q != 5'd0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_EXEC;
      S_EXEC: state_d = (taken || need_wb) ? S_RESP : S_IDLE;
      // Leave once neither request will still be pending next cycle.
      S_RESP: if (!redir_vld_d && !wb_vld_d) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.br_rdy  = (state_q == S_IDLE) && !kill;
    busy        = (state_q != S_IDLE);
    dbg_state_o = state_q;
  end

  // ---------------- capture on accept ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 3'd0;
      pc_q      <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      comp_q    <= 1'b0;
      use_imm_q <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= 5'd0;
    end else if (accept) begin
      op_q      <= bus.br_op;
      pc_q      <= bus.br_pc;
      imm_q     <= bus.br_imm;
      rs1_q     <= bus.rs1_data;
      rs2_q     <= bus.rs2_data;
      comp_q    <= bus.br_is_compressed;
      use_imm_q <= bus.br_use_imm;
      wr_vld_q  <= bus.br_wr_vld;
      wr_addr_q <= bus.br_wr_addr;
    end
  end

  // ---------------- response request next values ----------------
  always_comb begin
    redir_vld_d = redir_vld_q && !bus.redirect_ack;
    wb_vld_d    = wb_vld_q && !bus.wb_ack;
    flush_d     = 1'b0;
    if (state_q == S_EXEC) begin
      redir_vld_d = taken;
      wb_vld_d    = need_wb;
      flush_d     = taken;
    end
    if (kill) begin
      redir_vld_d = 1'b0;
      wb_vld_d    = 1'b0;
      flush_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_vld_q <= 1'b0;
      wb_vld_q    <= 1'b0;
      flush_q     <= 1'b0;
      redir_pc_q  <= '0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= '0;
    end else begin
      redir_vld_q <= redir_vld_d;
      wb_vld_q    <= wb_vld_d;
      flush_q     <= flush_d;
      // Payloads only load when their request is raised, so they stay
      // stable for the whole life of the request.
      if (state_q == S_EXEC && !kill) begin
        if (taken) redir_pc_q <= target;
        if (need_wb) begin
          wb_addr_q <= wr_addr_q;
          wb_data_q <= link;
        end
      end
    end
  end

  // ---------------- taken-redirect counter ----------------
  // A killed EXEC never reaches RESP, so it is not counted.
  assign inc = (state_q == S_EXEC) && taken && !kill;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                       cnt_d = '0;
    else if (inc && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.redirect_vld = redir_vld_q;
  assign bus.redirect_pc  = redir_pc_q;
  assign bus.flush        = flush_q;
  assign bus.wb_vld       = wb_vld_q;
  assign bus.wb_addr      = wb_addr_q;
  assign bus.wb_data      = wb_data_q;
  assign taken_cnt        = cnt_q;

endmodule

// File: doc/peak_dpu_br_ctrl.md
# peak_dpu_br_ctrl

Branch execution controller for the DPU, placed after the branch decoder and the register-file read stage. It accepts one decoded branch or jump per handshake and resolves the branch condition against the source operands. It computes the target and link values, then sequences the two completion side-effects, each through its own valid/ack handshake: a fetch redirect with a one-cycle pipeline flush pulse, and a link write-back. It also keeps a saturating count of taken redirects for performance monitoring.

## Interface
- `RST_PC_W`, default 32: width of the PC, target and data paths. Fixed at 32; the parameter is for documentation only.
- `CNT_W`, default 16: width of the taken-redirect counter.

Ports:
- `clk` in 1: clock. One clock domain only.
- `rst_n` in 1: reset, asynchronous and active-low.
- `br_vld` in 1: a decoded branch is presented.
- `br_rdy` out 1: the block can accept a branch.
- `br_op` in 3: operation code. JAL=0, JALR=1, BEQ=2, BNE=3, BLT=4, BGE=5, BLTU=6, BGEU=7.
- `br_pc` in 32: PC of the branch instruction.
- `br_is_compressed` in 1: the instruction is 16-bit.
- `br_imm` in 32: sign-extended immediate.
- `br_use_imm` in 1: JALR adds `br_imm` only when this is set.
- `br_wr_vld` in 1: a link write is requested.
- `br_wr_addr` in 5: link destination register.
- `rs1_data` in 32: operand rs1, valid together with `br_vld`.
- `rs2_data` in 32: operand rs2, valid together with `br_vld`.
- `kill` in 1: exception or interrupt abort.
- `redirect_vld` out 1: redirect request to fetch.
- `redirect_pc` out 32: redirect target.
- `redirect_ack` in 1: fetch accepts the redirect.
- `flush` out 1: one-cycle pulse that squashes younger instructions.
- `wb_vld` out 1: link write-back request.
- `wb_addr` out 5: link write-back register.
- `wb_data` out 32: link write-back value.
- `wb_ack` in 1: the register file accepts the write.
- `busy` out 1: high when the state is not IDLE.
- `cnt_clr` in 1: synchronous clear of the taken counter.
- `taken_cnt` out CNT_W: number of taken redirects, saturating.

## Operation
- FSM states: IDLE, EXEC, RESP.
- `br_rdy` = (state==IDLE) && !`kill`.
- Accept occurs when `br_vld` && `br_rdy`. On accept, all inputs are registered and the state moves to EXEC.
- EXEC computes, from registered values:
  - taken: JAL and JALR are always taken. BEQ/BNE use rs1==rs2 / rs1!=rs2. BLT/BGE use signed compare. BLTU/BGEU use unsigned compare.
  - target for JAL and Bxx: pc+imm, modulo 2^32.
  - target for JALR: (rs1 + (use_imm ? imm : 0)) & ~1.
  - link value: pc + (compressed ? 2 : 4), modulo 2^32.
  - need_wb: wr_vld && op∈{JAL,JALR} && wr_addr!=0.
- EXEC exit:
  - If taken || need_wb, go to RESP, setting `redirect_vld`=taken and `wb_vld`=need_wb.
  - Otherwise return to IDLE. A not-taken conditional branch has no side-effect.
- `flush` is high for exactly the single cycle of the EXEC→RESP transition when taken.
- In RESP, the two requests are independent:
  - Each `*_vld` holds, with stable payload, until its ack is sampled high. It then drops on the next cycle.
  - An ack while the matching vld is low is ignored.
  - The state returns to IDLE on the cycle after the last outstanding ack. Both acks in the same cycle is legal.
- `taken_cnt` increments by 1 on each EXEC→RESP transition with taken, and holds at all-ones.
  - `cnt_clr` has priority: if it coincides with an increment, the result is 0.
- `kill` in any state forces IDLE on the next edge and clears `redirect_vld`, `wb_vld` and `flush`. `taken_cnt` is not affected.
  - An ack arriving in the same cycle as `kill` counts as a completed handshake. The state still goes to IDLE.

## Timing
- Reset: state=IDLE. `br_rdy`=1 (if `kill` is low). `redirect_vld`, `wb_vld`, `flush` and `busy` are 0. `redirect_pc`, `wb_addr` and `wb_data` are 0. `taken_cnt` is 0.
- Accept in cycle T gives EXEC in T+1.
- From T+2: RESP outputs are valid, and `flush` pulses in T+2.
- With acks in T+2, the state is IDLE in T+3, `br_rdy`=1 in T+3, and the next accept can occur in T+3.
- A not-taken branch with no write-back is IDLE again in T+2.
- Throughput is at most one branch per 3 cycles. There are no combinational paths from ack or kill to `*_vld`. `br_rdy` depends combinationally on `kill`.

## Test plan
- BEQ, pc=0x100, imm=0x40, rs1=rs2=5, acks held high: `flush`=1 and `redirect_vld`=1 with `redirect_pc`=0x140 in T+2. `wb_vld` stays 0. `br_rdy`=1 in T+3. `taken_cnt`=1.
- BLT with rs1=0xFFFFFFFF, rs2=1: taken. BLTU with the same operands: not taken, no `flush`, and IDLE in T+2.
- JALR compressed, pc=0x200, rs1=0x1003, imm=0x10, use_imm=1, wr_addr=1:
  - `redirect_pc`=0x1012, `wb_addr`=1, `wb_data`=0x202.
  - With `wb_ack` delayed 3 cycles, `wb_vld` is held, `redirect_vld` drops after its ack, and the state is IDLE after `wb_ack`.
- JAL with wr_addr=0: `wb_vld` is never asserted; only the redirect occurs.
- Hold `redirect_ack` low and assert `kill` in RESP: all vlds are 0 on the next cycle and the state is IDLE.
  - `br_vld` together with `kill`: not accepted.
- Counter: preload by 0xFFFF taken branches, then run one more: the count stays 0xFFFF. `cnt_clr` on an increment cycle gives 0.
